// File: rtl/game_sequencer.sv
// Game flow sequencer: IDLE/RUN/PAUSED/OVER control, BCD score keeping
// and a score-dependent move strobe.
module game_sequencer #(
    parameter int unsigned TEST_N = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       collision,
    input  logic       point,
    input  logic [2:0] switches,
    output logic       move,
    output logic       freeze,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] bcd4,
    output logic [3:0] bcd5,
    output logic [1:0] state,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [23:0] score_q, score_d;
    logic [23:0] score_inc;
    logic        carry;
    logic [19:0] score_bin;
    logic [31:0] period;

    assign bcd0 = score_q[3:0];
    assign bcd1 = score_q[7:4];
    assign bcd2 = score_q[11:8];
    assign bcd3 = score_q[15:12];
    assign bcd4 = score_q[19:16];
    assign bcd5 = score_q[23:20];

    assign score_bin = 20'(bcd0)
                     + 20'(bcd1) * 20'd10
                     + 20'(bcd2) * 20'd100
                     + 20'(bcd3) * 20'd1000
                     + 20'(bcd4) * 20'd10000
                     + 20'(bcd5) * 20'd100000;

    always_comb begin
        if (TEST_N != 0)              period = 32'(TEST_N);
        else if (switches == 3'b010)  period = 32'd500;
        else if (score_bin < 20'd5)   period = 32'd400;
        else if (score_bin < 20'd10)  period = 32'd380;
        else if (score_bin < 20'd20)  period = 32'd360;
        else if (score_bin < 20'd30)  period = 32'd340;
        else if (score_bin < 20'd35)  period = 32'd320;
        else if (score_bin < 20'd40)  period = 32'd300;
        else if (score_bin < 20'd45)  period = 32'd280;
        else if (score_bin < 20'd50)  period = 32'd260;
        else if (score_bin < 20'd55)  period = 32'd240;
        else if (score_bin < 20'd60)  period = 32'd220;
        else                          period = 32'd200;
    end

    // Ripple-carry BCD increment; saturation is applied by the caller.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (carry) begin
                if (score_q[4*k +: 4] == 4'd9) begin
                    score_inc[4*k +: 4] = 4'd0;
                end else begin
                    score_inc[4*k +: 4] = score_q[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    assign move      = (state_q == RUN) && (cnt_q >= period);
    assign freeze    = (state_q != RUN);
    assign game_over = (state_q == OVER);
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 32'd0;
                    score_d = 24'd0;
                end
            end
            RUN: begin
                if (collision) begin
                    state_d = OVER;
                    cnt_d   = 32'd0;
                end else begin
                    if (point && score_q != 24'h999999) score_d = score_inc;
                    // The counter only advances while RUN is kept.
                    if (move)       cnt_d = 32'd0;
                    else if (pause) cnt_d = cnt_q;
                    else            cnt_d = cnt_q + 32'd1;
                    if (pause) state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 32'd0;
                    score_d = 24'd0;
                end else if (pause) begin
                    state_d = RUN;
                end
            end
            OVER: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 32'd0;
                    score_d = 24'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            score_q <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
        end
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter TEST_N, default 0: 0 selects the score-based tick-period table; any nonzero value forces tick period N = TEST_N for simulation.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse from a debounced key; starts or restarts a game.
REQ-005 pause  input  1  single-cycle pulse; toggles between RUN and PAUSED.
REQ-006 collision  input  1  single-cycle pulse; the player has lost.
REQ-007 point  input  1  single-cycle pulse; add one to the score.
REQ-008 switches  input  3  cheat switches; 3'b010 enables slow motion.
REQ-009 move  output  1  one-cycle game-update strobe.
REQ-010 freeze  output  1  high whenever state is not RUN.
REQ-011 bcd0..bcd5  output  4 each  score digits, where bcd0 is the least significant digit.
REQ-012 state  output  2  encoding: IDLE=0, RUN=1, PAUSED=2, OVER=3.
REQ-013 game_over  output  1  high exactly when state is OVER.

Function
REQ-014 The block SHALL implement FSM states IDLE, RUN, PAUSED and OVER.
REQ-015 IDLE: start -> RUN, clearing the score and the tick counter; all other inputs are ignored.
REQ-016 RUN: collision -> OVER; otherwise pause -> PAUSED; otherwise remain in RUN.
REQ-017 RUN priority: collision beats pause, and collision beats point (the point is dropped).
REQ-018 PAUSED: pause -> RUN with the tick counter retained; start -> RUN with score and counter cleared; collision and point are ignored.
REQ-019 PAUSED: when pause and start arrive together, start wins.
REQ-020 OVER: start -> RUN with score and counter cleared; the score is otherwise held for display.
REQ-021 Score: point in RUN SHALL increment the 6-digit BCD value by 1 with ripple carry (9 -> 0, next digit +1).
REQ-022 Score SHALL saturate at 999999; a further point leaves it unchanged.
REQ-023 Each digit SHALL stay within 0-9 at all times.
REQ-024 Binary score SHALL be computed combinationally as sum(bcdk * 10^k), 20 bits wide, for period selection.
REQ-025 Period N (when TEST_N=0, slow motion off), by binary score:
- <5: 400
- <10: 380
- <20: 360
- <30: 340
- <35: 320
- <40: 300
- <45: 280
- <50: 260
- <55: 240
- <60: 220
- otherwise: 200
REQ-026 Slow motion (switches==3'b010, TEST_N=0) SHALL force N=500, overriding the score table.
REQ-027 The tick counter SHALL be 32-bit and increment only in RUN.
REQ-028 When the counter >= N, move SHALL be 1 for that cycle and the counter SHALL return to 0 on the next edge, giving a period of N+1 cycles.
REQ-029 A mid-count drop in N SHALL trigger move on the next cycle, via the >= comparison.
REQ-030 move SHALL be 0 in IDLE, PAUSED and OVER.
REQ-031 On entering OVER or IDLE, the counter SHALL be 0 on the next cycle.
REQ-032 move, freeze, state and game_over SHALL be decoded combinationally from registered state and counter.

Reset
REQ-033 reset low SHALL immediately force: state=IDLE, counter=0, all bcd digits=0.
REQ-034 While reset is low, outputs SHALL be: move=0, freeze=1, game_over=0.
REQ-035 Reset asserted mid-game (any state) SHALL abandon the game without further move pulses.
REQ-036 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-037 TEST_N=5: reset, start, hold 20 cycles -> move high on cycles 6, 12, 18 after start; freeze=0.
REQ-038 TEST_N=0: start, 5 point pulses (score 5) -> N=380; set switches=3'b010 -> N=500; switches=3'b000 -> N back to 380.
REQ-039 Score 000009 + point -> bcd0=0, bcd1=1; score 999999 + point -> stays 999999.
REQ-040 RUN, counter=3, pause -> PAUSED, freeze=1, no move for 50 cycles; pause again -> move 3 cycles later (TEST_N=5).
REQ-041 collision and point in the same RUN cycle -> state=OVER, game_over=1, score unchanged; then start -> RUN, score 000000.
REQ-042 Assert reset asynchronously between clock edges while in RUN with score 42 -> immediate state=IDLE, bcd all 0, freeze=1, move=0.
